// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the two-port SRAM arbiter: widths, FSM encodings, port IDs
// and the round-robin pick rule.
package mem_port_arbiter_pkg;

    localparam int ARB_AW = 5;
    localparam int ARB_DW = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    localparam logic P_LOAD = 1'b0;
    localparam logic P_WB   = 1'b1;

    // On a tie the port that did not win last time takes the grant.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last_gnt);
        return (req0 && req1) ? ~last_gnt : req1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One requester port of the SRAM arbiter: req/ack handshake plus the latched
// transaction fields and the per-port read result.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
);
    logic          req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, wr, addr, wdata, input ack, rdata);
    modport slave  (input req, wr, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arb_rr.sv
// Combinational two-way round-robin picker for the SRAM arbiter.
module mem_arb_rr
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic valid,
    output logic winner
);
    assign valid  = req0 | req1;
    assign winner = rr_pick(req0, req1, last_gnt);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between the operand loader (p0) and
// the ALU writeback port (p1); owns every SRAM control signal.
//   state   | meaning
//   S_IDLE  | waiting for a request, mem_cs low
//   S_ISSUE | one cycle with mem_cs high, address/strobe presented to the SRAM
//   S_WAIT  | read only: counting down RD_LAT, data captured when count is 1
//   S_ACK   | one-cycle ack pulse to the granted port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW     = ARB_AW,
    parameter int DW     = ARB_DW,
    parameter int RD_LAT = 1
)(
    input  logic          clk,
    input  logic          reset,
    mem_port_arbiter_if.slave p0,
    mem_port_arbiter_if.slave p1,
    output logic          mem_cs,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          gnt_id
);
    localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

    logic [1:0]    state;
    logic [1:0]    cnt;
    logic          last_gnt;
    logic          gnt_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          rr_valid;
    logic          rr_winner;

    mem_arb_rr u_rr (
        .req0     (p0.req),
        .req1     (p1.req),
        .last_gnt (last_gnt),
        .valid    (rr_valid),
        .winner   (rr_winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            last_gnt  <= 1'b1;
            gnt_q     <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rr_valid) begin
                        gnt_q     <= rr_winner;
                        last_gnt  <= rr_winner;
                        mem_wr    <= (rr_winner == P_WB) ? p1.wr    : p0.wr;
                        mem_addr  <= (rr_winner == P_WB) ? p1.addr  : p0.addr;
                        mem_wdata <= (rr_winner == P_WB) ? p1.wdata : p0.wdata;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_wr) begin
                        state <= S_ACK;
                    end else begin
                        cnt   <= RD_LAT_C;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Count of 1 means the SRAM output is valid on this edge.
                    if (cnt == 2'd1) begin
                        if (gnt_q == P_WB) rdata1_q <= mem_rdata;
                        else               rdata0_q <= mem_rdata;
                        state <= S_ACK;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_cs   = (state == S_ISSUE);
    assign busy     = (state != S_IDLE);
    assign gnt_id   = gnt_q;
    assign p0.ack   = (state == S_ACK) && (gnt_q == P_LOAD);
    assign p1.ack   = (state == S_ACK) && (gnt_q == P_WB);
    assign p0.rdata = rdata0_q;
    assign p1.rdata = rdata1_q;

endmodule
